display_writer: RTL and testbench

Parametrised character-stream front end for the `dsp` character display. It accepts a byte stream through a valid/ready handshake and maintains a cursor. It translates printable bytes and a small set of control codes into single-cycle `dsp` write transactions, including automatic full-screen and row clears. It sits between any text source (UART receiver, CPU port, message sequencer) and the `dsp` write port, replacing hand-driven `dsp_row`/`dsp_col`/`dsp_wr` wiring in top-level designs.

---
 rtl/display_writer.sv | 227 ++++++++++++++++++++++
 tb/tb_display_writer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_writer.sv
// display_writer: byte stream -> dsp cell writes with cursor, wrap, row/screen clears; writes land 1 cycle after the accepting cycle.
// in_ready only in IDLE (stalls during clears); optional cursor glyph via DISPLAY_WRITER_CURSOR_EN.
module display_writer #(
    parameter int         ROWS        = 30,
    parameter int         COLS        = 80,
    parameter int         ROW_W       = 5,
    parameter int         COL_W       = 7,
    parameter logic [7:0] CLEAR_ATTR  = 8'h07,
    parameter logic [7:0] CURSOR_CHAR = 8'h5F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic [7:0]       in_attr,
    output logic [ROW_W-1:0] dsp_row,
    output logic [COL_W-1:0] dsp_col,
    output logic             dsp_en,
    output logic             dsp_wr,
    output logic [15:0]      dsp_wr_data,
    output logic             busy,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_CLRROW
`ifdef DISPLAY_WRITER_CURSOR_EN
        , S_ERASE,
        S_DRAW
`endif
    } state_t;

`ifdef DISPLAY_WRITER_CURSOR_EN
    localparam state_t S_DONE = S_DRAW;
`else
    localparam state_t S_DONE = S_IDLE;
`endif

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [15:0]      BLANK    = {CLEAR_ATTR, 8'h20};

    state_t             r_state, w_state;
    logic [ROW_W-1:0]   r_cur_row, w_cur_row, r_cnt_row, w_cnt_row, w_next_row;
    logic [COL_W-1:0]   r_cur_col, w_cur_col, r_cnt_col, w_cnt_col;
    logic               r_dsp_en, w_wr;
    logic [ROW_W-1:0]   r_dsp_row, w_row;
    logic [COL_W-1:0]   r_dsp_col, w_col;
    logic [15:0]        r_dsp_data, w_data;
    logic               w_printable;
`ifdef DISPLAY_WRITER_CURSOR_EN
    logic [7:0]         r_pend, w_pend;
`endif

    assign w_next_row  = (r_cur_row == LAST_ROW) ? '0 : r_cur_row + 1'b1;
    assign w_printable = (in_char >= 8'h20) && (in_char != 8'h7F);

    always_comb begin
        w_state   = r_state;
        w_cur_row = r_cur_row;
        w_cur_col = r_cur_col;
        w_cnt_row = r_cnt_row;
        w_cnt_col = r_cnt_col;
        w_wr      = 1'b0;
        w_row     = r_dsp_row;
        w_col     = r_dsp_col;
        w_data    = r_dsp_data;
`ifdef DISPLAY_WRITER_CURSOR_EN
        w_pend    = r_pend;
`endif
        case (r_state)
            S_CLEAR: begin
                w_wr   = 1'b1;
                w_row  = r_cnt_row;
                w_col  = r_cnt_col;
                w_data = BLANK;
                if (r_cnt_col == LAST_COL) begin
                    w_cnt_col = '0;
                    if (r_cnt_row == LAST_ROW) begin
                        w_cnt_row = '0;
                        w_cur_row = '0;
                        w_cur_col = '0;
                        w_state   = S_DONE;
                    end else begin
                        w_cnt_row = r_cnt_row + 1'b1;
                    end
                end else begin
                    w_cnt_col = r_cnt_col + 1'b1;
                end
            end
            S_CLRROW: begin
                w_wr   = 1'b1;
                w_row  = r_cur_row;
                w_col  = r_cnt_col;
                w_data = BLANK;
                if (r_cnt_col == LAST_COL) begin
                    w_cnt_col = '0;
                    w_state   = S_DONE;
                end else begin
                    w_cnt_col = r_cnt_col + 1'b1;
                end
            end
            S_IDLE: begin
                if (in_valid && w_printable) begin
                    w_wr   = 1'b1;
                    w_row  = r_cur_row;
                    w_col  = r_cur_col;
                    w_data = {in_attr, in_char};
                    if (r_cur_col == LAST_COL) begin
                        w_cur_col = '0;
                        w_cur_row = w_next_row;
                        w_cnt_col = '0;
                        w_state   = S_CLRROW;
                    end else begin
                        w_cur_col = r_cur_col + 1'b1;
                        w_state   = S_DONE;
                    end
                end else if (in_valid) begin
                    case (in_char)
`ifdef DISPLAY_WRITER_CURSOR_EN
                        8'h0A, 8'h0D, 8'h08: begin
                            w_pend  = in_char;
                            w_state = S_ERASE;
                        end
`else
                        8'h0A: begin
                            w_cur_col = '0;
                            w_cur_row = w_next_row;
                            w_cnt_col = '0;
                            w_state   = S_CLRROW;
                        end
                        8'h0D: w_cur_col = '0;
                        8'h08: begin
                            if (r_cur_col != '0) begin
                                w_cur_col = r_cur_col - 1'b1;
                                w_wr      = 1'b1;
                                w_row     = r_cur_row;
                                w_col     = r_cur_col - 1'b1;
                                w_data    = BLANK;
                            end
                        end
`endif
                        8'h0C: begin
                            w_cnt_row = '0;
                            w_cnt_col = '0;
                            w_state   = S_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
`ifdef DISPLAY_WRITER_CURSOR_EN
            // Blank the old glyph, then apply the deferred move; DRAW repaints the cell BS lands on.
            S_ERASE: begin
                w_wr    = 1'b1;
                w_row   = r_cur_row;
                w_col   = r_cur_col;
                w_data  = BLANK;
                w_state = S_DRAW;
                case (r_pend)
                    8'h0A: begin
                        w_cur_col = '0;
                        w_cur_row = w_next_row;
                        w_cnt_col = '0;
                        w_state   = S_CLRROW;
                    end
                    8'h0D:   w_cur_col = '0;
                    default: if (r_cur_col != '0) w_cur_col = r_cur_col - 1'b1;
                endcase
            end
            S_DRAW: begin
                w_wr    = 1'b1;
                w_row   = r_cur_row;
                w_col   = r_cur_col;
                w_data  = {CLEAR_ATTR, CURSOR_CHAR};
                w_state = S_IDLE;
            end
`endif
            default: w_state = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_CLEAR;
            r_cur_row  <= '0;
            r_cur_col  <= '0;
            r_cnt_row  <= '0;
            r_cnt_col  <= '0;
            r_dsp_en   <= 1'b0;
            r_dsp_row  <= '0;
            r_dsp_col  <= '0;
            r_dsp_data <= '0;
`ifdef DISPLAY_WRITER_CURSOR_EN
            r_pend     <= '0;
`endif
        end else begin
            r_state    <= w_state;
            r_cur_row  <= w_cur_row;
            r_cur_col  <= w_cur_col;
            r_cnt_row  <= w_cnt_row;
            r_cnt_col  <= w_cnt_col;
            r_dsp_en   <= w_wr;
            r_dsp_row  <= w_row;
            r_dsp_col  <= w_col;
            r_dsp_data <= w_data;
`ifdef DISPLAY_WRITER_CURSOR_EN
            r_pend     <= w_pend;
`endif
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign dsp_en      = r_dsp_en;
    assign dsp_wr      = r_dsp_en;
    assign dsp_row     = r_dsp_row;
    assign dsp_col     = r_dsp_col;
    assign dsp_wr_data = r_dsp_data;
    assign cursor_row  = r_cur_row;
    assign cursor_col  = r_cur_col;

endmodule

// File: tb/tb_display_writer.sv
// Bench for display_writer (4x8 screen, cursor option off): expected dsp writes queued by stimulus, popped by a monitor.
module tb_display_writer;
    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int ROW_W = 2;
    localparam int COL_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_char;
    logic [7:0]       in_attr;
    logic [ROW_W-1:0] dsp_row;
    logic [COL_W-1:0] dsp_col;
    logic             dsp_en;
    logic             dsp_wr;
    logic [15:0]      dsp_wr_data;
    logic             busy;
    logic [ROW_W-1:0] cursor_row;
    logic [COL_W-1:0] cursor_col;

    display_writer #(
        .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
        .CLEAR_ATTR(8'h07), .CURSOR_CHAR(8'h5F)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_attr(in_attr),
        .dsp_row(dsp_row), .dsp_col(dsp_col), .dsp_en(dsp_en), .dsp_wr(dsp_wr),
        .dsp_wr_data(dsp_wr_data), .busy(busy),
        .cursor_row(cursor_row), .cursor_col(cursor_col)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROW_W-1:0] r;
        logic [COL_W-1:0] c;
        logic [15:0]      d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (dsp_en === 1'b1) begin
            n_cmp++;
            if (dsp_wr !== 1'b1) begin
                n_bad++;
                $display("FAIL dsp_wr_strobe: got %b, required 1", dsp_wr);
            end
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL dsp_write: got (%0d,%0d)=%h, required no write",
                         dsp_row, dsp_col, dsp_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.r !== dsp_row || mon_e.c !== dsp_col || mon_e.d !== dsp_wr_data) begin
                    n_bad++;
                    $display("FAIL dsp_write: got (%0d,%0d)=%h, required (%0d,%0d)=%h",
                             dsp_row, dsp_col, dsp_wr_data, mon_e.r, mon_e.c, mon_e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input int r, input int c, input logic [15:0] d);
        wr_t w;
        w.r = ROW_W'(r);
        w.c = COL_W'(c);
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic push_clrrow(input int r);
        for (int c = 0; c < COLS; c++) push_w(r, c, 16'h0720);
    endtask

    task automatic push_clrall();
        for (int r = 0; r < ROWS; r++) push_clrrow(r);
    endtask

    // Holds the byte until accepted; optionally requires in_ready already high on entry.
    task automatic send(input logic [7:0] c, input logic [7:0] a, input string name, input bit need_ready);
        int n;
        in_char  = c;
        in_attr  = a;
        in_valid = 1'b1;
        if (need_ready) check({name, "_ready"}, int'(in_ready), 1);
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check({name, "_accept_timeout"}, n, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic stall(output int n);
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic check_cur(input string name, input int r, input int c);
        check({name, "_cur_row"}, int'(cursor_row), r);
        check({name, "_cur_col"}, int'(cursor_col), c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        in_attr  = 8'h00;
        tick();
        tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_dsp_en", int'(dsp_en), 0);
        check("rst_dsp_wr", int'(dsp_wr), 0);
        check("rst_dsp_addr", int'({dsp_row, dsp_col}), 0);
        check("rst_dsp_data", int'(dsp_wr_data), 0);
        check_cur("rst", 0, 0);

        // Power-up clear: 32 blanks row-major, then ready.
        push_clrall();
        in_valid = 1'b1;
        in_char  = 8'h41;
        reset    = 1'b0;
        in_valid = 1'b0;
        stall(n);
        check("reset_clear_len", n, 32);
        check_cur("after_reset", 0, 0);

        // Back-to-back printables, no stall.
        push_w(0, 0, 16'h1F48);
        push_w(0, 1, 16'h1F49);
        send(8'h48, 8'h1F, "h", 1'b1);
        send(8'h49, 8'h1F, "i", 1'b1);
        check_cur("hi", 0, 2);
        check("hi_ready_after", int'(in_ready), 1);

        // Three LFs walk down to row 3, clearing each new row.
        push_clrrow(1);
        send(8'h0A, 8'h00, "lf1", 1'b1);
        stall(n);
        check("lf_stall", n, COLS);
        push_clrrow(2);
        send(8'h0A, 8'h00, "lf2", 1'b0);
        push_clrrow(3);
        send(8'h0A, 8'h00, "lf3", 1'b0);
        check_cur("lf3", 3, 0);

        // Fill row 3; last column wraps to row 0 and clears it.
        for (int i = 0; i < COLS; i++) begin
            push_w(3, i, {8'h2A, 8'(8'h61 + i)});
            if (i == COLS - 1) push_clrrow(0);
            send(8'(8'h61 + i), 8'h2A, "fill", 1'b0);
        end
        check_cur("wrap", 0, 0);
        stall(n);
        check("wrap_stall", n, COLS);
        push_w(0, 0, 16'h2A5A);
        send(8'h5A, 8'h2A, "ninth", 1'b1);
        check_cur("ninth", 0, 1);

        // CR, then BS at column 0: no writes, no stall.
        send(8'h0D, 8'h00, "cr0", 1'b1);
        check_cur("cr0", 0, 0);
        send(8'h08, 8'h00, "bs0", 1'b1);
        check_cur("bs0", 0, 0);
        check("bs0_nostall", int'(in_ready), 1);

        // Move to (2,5), then CR, BS after a print, and an ignored control code.
        push_clrrow(1);
        send(8'h0A, 8'h00, "lf4", 1'b1);
        push_clrrow(2);
        send(8'h0A, 8'h00, "lf5", 1'b0);
        for (int i = 0; i < 5; i++) begin
            push_w(2, i, {8'h2A, 8'(8'h30 + i)});
            send(8'(8'h30 + i), 8'h2A, "digit", 1'b0);
        end
        check_cur("at_2_5", 2, 5);
        send(8'h0D, 8'h00, "cr25", 1'b1);
        check_cur("cr25", 2, 0);
        check("cr_nostall", int'(in_ready), 1);
        push_w(2, 0, 16'h2A78);
        send(8'h78, 8'h2A, "x", 1'b1);
        push_w(2, 0, 16'h0720);
        send(8'h08, 8'h00, "bs1", 1'b1);
        check_cur("bs1", 2, 0);
        send(8'h07, 8'h00, "bel", 1'b1);
        check_cur("bel", 2, 0);
        check("bel_nostall", int'(in_ready), 1);

        // FF mid-screen: full clear and home.
        push_clrall();
        send(8'h0C, 8'h00, "ff1", 1'b1);
        stall(n);
        check("ff_stall", n, ROWS * COLS);
        check_cur("ff_home", 0, 0);

        // FF again, reset ten cycles in: clear restarts from (0,0).
        push_w(0, 0, 16'h2A41);
        send(8'h41, 8'h2A, "a", 1'b1);
        push_clrall();
        send(8'h0C, 8'h00, "ff2", 1'b1);
        repeat (10) tick();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_char  = 8'h42;
        tick();
        exp_q.delete();
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_dsp_en", int'(dsp_en), 0);
        in_valid = 1'b0;
        push_clrall();
        reset = 1'b0;
        stall(n);
        check("abort_clear_len", n, ROWS * COLS);
        check_cur("abort_home", 0, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
